// File: rtl/cla_div_pkg.sv
// Shared definitions for the sequential signed divider.
// - div_state_t : divider FSM encoding
// - DIV_ZERO_Q  : quotient forced out on divide by zero (all ones, sliced to width)
// - div_cnt_w() : width of the iteration down-counter for a given operand width
package cla_div_pkg;

    typedef enum logic [2:0] {IDLE, CALC, CORR, SIGN, DONE} div_state_t;

    localparam logic [31:0] DIV_ZERO_Q = '1;

    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/cla_signed_add_sub.sv
// Carry-lookahead adder/subtractor (parallel-prefix carry tree).
// Ports:
//   a, b      operands, DATA_IN_W bits
//   sub_nadd  1: sum = a - b, 0: sum = a + b
//   sum       result, DATA_IN_W bits (wraps)
//   carry_o   carry out of the msb
module cla_signed_add_sub #(
    parameter int DATA_IN_W = 16
) (
    input  logic [DATA_IN_W-1:0] a,
    input  logic [DATA_IN_W-1:0] b,
    input  logic                 sub_nadd,
    output logic [DATA_IN_W-1:0] sum,
    output logic                 carry_o
);
    localparam int LV = $clog2(DATA_IN_W);

    logic [DATA_IN_W-1:0] bx, g, p, gp, pp;
    logic [DATA_IN_W:0]   c;

    always_comb begin
        // Subtract as a + ~b + 1: invert b and feed sub_nadd in as carry-in.
        bx = b ^ {DATA_IN_W{sub_nadd}};
        g  = a & bx;
        p  = a ^ bx;
        gp = g;
        pp = p;
        // Kogge-Stone prefix: walking i downward keeps lower bits at the
        // previous level's values while this level is being formed.
        for (int k = 0; k < LV; k++) begin
            for (int i = DATA_IN_W - 1; i >= (1 << k); i--) begin
                gp[i] = gp[i] | (pp[i] & gp[i - (1 << k)]);
                pp[i] = pp[i] & pp[i - (1 << k)];
            end
        end
        c[0]           = sub_nadd;
        c[DATA_IN_W:1] = gp | (pp & {DATA_IN_W{sub_nadd}});
        sum            = p ^ c[DATA_IN_W-1:0];
        carry_o        = c[DATA_IN_W];
    end

endmodule

// File: rtl/cla_signed_div_seq.sv
// Sequential signed divider, non-restoring, one quotient bit per cycle.
// All add/sub work of the iteration, the remainder correction and the
// remainder sign fix-up goes through one shared cla_signed_add_sub.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid_i / in_ready_o    operand handshake (ready only while idle)
//   dividend_i, divisor_i      signed operands, DATA_IN_W bits
//   out_valid_o / out_ready_i  result handshake (result held until taken)
//   quotient_o                 signed quotient, truncated toward zero
//   remainder_o                signed remainder, sign of the dividend
//   div_by_zero_o, overflow_o  divisor was 0 / MIN divided by -1
module cla_signed_div_seq
    import cla_div_pkg::*;
#(
    parameter int DATA_IN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_IN_W-1:0] dividend_i,
    input  logic [DATA_IN_W-1:0] divisor_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_IN_W-1:0] quotient_o,
    output logic [DATA_IN_W-1:0] remainder_o,
    output logic                 div_by_zero_o,
    output logic                 overflow_o
);
    localparam int W  = DATA_IN_W;
    localparam int CW = div_cnt_w(DATA_IN_W);

    div_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W:0]    p;          // partial remainder, signed, one bit wider than operands
    logic [W-1:0]  q, d;       // quotient shift register / divisor magnitude
    logic          neg_q, neg_r, dz, ovf;

    logic [W:0]    as_a, as_b, as_sum;
    logic          as_sub, co_unused;
    logic [W-1:0]  dvd_mag, dvs_mag, q_neg;

    // |MIN| = 2^(W-1) still fits as an unsigned W-bit magnitude.
    assign dvd_mag = dividend_i[W-1] ? (~dividend_i + 1'b1) : dividend_i;
    assign dvs_mag = divisor_i[W-1]  ? (~divisor_i + 1'b1)  : divisor_i;
    // The shared adder is busy negating the remainder in SIGN, so the
    // quotient gets its own negate.
    assign q_neg   = '0 - q;

    cla_signed_add_sub #(.DATA_IN_W(W + 1)) u_add_sub (
        .a        (as_a),
        .b        (as_b),
        .sub_nadd (as_sub),
        .sum      (as_sum),
        .carry_o  (co_unused)
    );

    // Adder operand mux: iterate in CALC, correct in CORR, 0 - P in SIGN.
    always_comb begin
        as_a   = '0;
        as_b   = {1'b0, d};
        as_sub = 1'b0;
        case (state)
            CALC: begin
                as_a   = {p[W-1:0], q[W-1]};   // {P,Q} << 1
                as_sub = ~p[W];
            end
            CORR: as_a = p;
            SIGN: begin
                as_b   = p;
                as_sub = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_nxt = CALC;
            end
            CALC: if (cnt == CW'(1)) state_nxt = CORR;
            CORR: state_nxt = SIGN;
            SIGN: state_nxt = DONE;
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            p             <= '0;
            q             <= '0;
            d             <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            ovf           <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid_i) begin
                    p     <= '0;
                    q     <= dvd_mag;
                    d     <= dvs_mag;
                    cnt   <= CW'(W);
                    neg_r <= dividend_i[W-1];
                    neg_q <= dividend_i[W-1] ^ divisor_i[W-1];
                    dz    <= (divisor_i == '0);
                    ovf   <= (dividend_i == {1'b1, {(W-1){1'b0}}}) && (divisor_i == '1);
                end
                CALC: begin
                    p   <= as_sum;
                    q   <= {q[W-2:0], ~as_sum[W]};
                    cnt <= cnt - 1'b1;
                end
                CORR: if (p[W]) p <= as_sum;
                SIGN: begin
                    // With D = 0 the iteration leaves Q all ones and P = |dividend|,
                    // so only the quotient needs overriding; the remainder comes out
                    // as the dividend. MIN / -1 wraps naturally to MIN.
                    quotient_o    <= dz ? DIV_ZERO_Q[W-1:0] : (neg_q ? q_neg : q);
                    remainder_o   <= neg_r ? as_sum[W-1:0] : p[W-1:0];
                    div_by_zero_o <= dz;
                    overflow_o    <= ovf;
                end
                DONE: if (out_ready_i) begin
                    div_by_zero_o <= 1'b0;
                    overflow_o    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_signed_div_seq.sv
module tb_cla_signed_div_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [W-1:0] dividend_i, divisor_i, quotient_o, remainder_o;
    logic         div_by_zero_o, overflow_o;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    cla_signed_div_seq #(.DATA_IN_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   qi, ri;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a[W-1:0];
            e.dz = 1'b1;
        end else if (a == -32768 && b == -1) begin
            e.q   = 16'h8000;
            e.r   = '0;
            e.ovf = 1'b1;
        end else begin
            qi  = a / b;
            ri  = a % b;
            e.q = qi[W-1:0];
            e.r = ri[W-1:0];
        end
        return e;
    endfunction

    // One full transaction: push expectation, drive, measure latency, apply
    // 'hold' cycles of backpressure, pop and compare at the handshake.
    // pulse >= 0 raises in_valid_i for one cycle that many edges into CALC.
    task automatic run_op(input int a, input int b, input int hold, input int pulse);
        exp_t e;
        int   lat;
        sb.push_back(model(a, b));
        lat = 0;
        while (!in_ready_o && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("in_ready_wait", in_ready_o, 1);
        dividend_i = a[W-1:0];
        divisor_i  = b[W-1:0];
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        dividend_i = 16'h5A5A;
        divisor_i  = 16'h0003;
        lat = 0;
        while (!out_valid_o && lat < 50) begin
            if (lat == pulse) begin
                in_valid_i = 1'b1;
                check("busy_in_ready", in_ready_o, 0);
            end else begin
                in_valid_i = 1'b0;
            end
            @(posedge clk); #1; lat++;
        end
        in_valid_i = 1'b0;
        check("latency", lat, W + 2);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", out_valid_o, 1);
            check("hold_in_ready", in_ready_o, 0);
            check("hold_q", quotient_o, e.q);
            check("hold_r", remainder_o, e.r);
            @(posedge clk); #1;
        end
        out_ready_i = 1'b1;
        check("valid", out_valid_o, 1);
        check("quotient", quotient_o, e.q);
        check("remainder", remainder_o, e.r);
        check("div_by_zero", div_by_zero_o, e.dz);
        check("overflow", overflow_o, e.ovf);
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        check("ready_after_hs", in_ready_o, 1);
        check("valid_after_hs", out_valid_o, 0);
        check("dz_cleared", div_by_zero_o, 0);
        check("ovf_cleared", overflow_o, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dvd[$];
        int  dvs[$];
        bit  stop;
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        dividend_i  = '0;
        divisor_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_q", quotient_o, 0);
        check("rst_r", remainder_o, 0);
        check("rst_dz", div_by_zero_o, 0);
        check("rst_ovf", overflow_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases, including sign combinations and special values.
        run_op(100, 7, 0, -1);
        run_op(-100, 7, 0, -1);
        run_op(100, -7, 0, -1);
        run_op(-100, -7, 0, -1);
        run_op(-32768, -1, 0, -1);
        run_op(5, 0, 0, -1);
        run_op(-5, 0, 0, -1);
        run_op(-32768, 1, 0, -1);
        run_op(-32768, -32768, 0, -1);
        run_op(32767, -32768, 0, -1);

        // Backpressure for 10 cycles with a stray in_valid_i pulse mid-CALC.
        run_op(-100, 7, 10, 5);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_stray_result", out_valid_o, 0);
        end

        // Reset in CALC cycle 5 aborts the operation.
        dividend_i = 16'd100;
        divisor_i  = 16'd7;
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", in_ready_o, 1);
        check("abort_out_valid", out_valid_o, 0);
        run_op(9, 3, 0, -1);

        // Strided sweep over the 8-bit signed range with random backpressure.
        for (int i = -128; i <= 127; i += 15) dvd.push_back(i);
        dvd.push_back(0); dvd.push_back(-1); dvd.push_back(1);
        for (int j = -128; j <= 127; j += 17) dvs.push_back(j);
        dvs.push_back(0); dvs.push_back(1); dvs.push_back(-1); dvs.push_back(2);
        stop = 1'b0;
        foreach (dvd[i]) begin
            foreach (dvs[j]) begin
                if (!stop) begin
                    run_op(dvd[i], dvs[j], $urandom_range(0, 3), -1);
                    if (n_err != 0) stop = 1'b1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
